// File: rtl/seq_pattern_generator.sv
// Emits the 7-symbol detector pattern per run, with repeats, gaps and abort; outputs registered.
// First symbol is visible from the edge that samples start; SEND holds its symbol while ready=0.
module seq_pattern_generator #(
   parameter logic [2:0]  IDLE_SYMBOL = 3'b111,
   parameter int unsigned GAP_CYCLES  = 0,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             abort,
   input  logic             ready,
   output logic [2:0]       data,
   output logic             data_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] seq_count
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

   state_t           state, state_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       gap_cnt, gap_cnt_nxt;
   logic [CNT_W-1:0] target, target_nxt;
   logic [CNT_W-1:0] cnt_nxt, cnt_inc;
   logic             done_nxt;

   function automatic logic [2:0] pattern_sym(input logic [2:0] i);
      case (i)
         3'd0:    pattern_sym = 3'b001;
         3'd1:    pattern_sym = 3'b101;
         3'd2:    pattern_sym = 3'b110;
         3'd3:    pattern_sym = 3'b000;
         3'd4:    pattern_sym = 3'b110;
         3'd5:    pattern_sym = 3'b110;
         3'd6:    pattern_sym = 3'b011;
         default: pattern_sym = 3'b001;
      endcase
   endfunction

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      gap_cnt_nxt = gap_cnt;
      target_nxt  = target;
      cnt_nxt     = seq_count;
      done_nxt    = 1'b0;
      cnt_inc     = seq_count + CNT_W'(1);
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt  = SEND;
               idx_nxt    = 3'd0;
               cnt_nxt    = '0;
               target_nxt = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
            end
         end
         SEND: begin
            if (abort) begin
               state_nxt = IDLE;
               idx_nxt   = 3'd0;
            end else if (ready) begin
               if (idx == 3'd6) begin
                  cnt_nxt = cnt_inc;
                  idx_nxt = 3'd0;
                  // >= keeps the count from ever running past the latched target
                  if (cnt_inc >= target) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else if (GAP_CYCLES == 0) begin
                     state_nxt = SEND;
                  end else begin
                     state_nxt   = GAP;
                     gap_cnt_nxt = GAP_LOAD;
                  end
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (gap_cnt == 8'd0) begin
               state_nxt = SEND;
               idx_nxt   = 3'd0;
            end else begin
               gap_cnt_nxt = gap_cnt - 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from next-state values so they change on the same edge as the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= 3'd0;
         gap_cnt    <= 8'd0;
         target     <= CNT_W'(1);
         seq_count  <= '0;
         data       <= IDLE_SYMBOL;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         gap_cnt    <= gap_cnt_nxt;
         target     <= target_nxt;
         seq_count  <= cnt_nxt;
         data       <= (state_nxt == SEND) ? pattern_sym(idx_nxt) : IDLE_SYMBOL;
         data_valid <= (state_nxt == SEND);
         busy       <= (state_nxt != IDLE);
         done       <= done_nxt;
      end
   end

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Bench for seq_pattern_generator: one instance with no gaps, one with two-cycle gaps, shared inputs.
module tb_seq_pattern_generator;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       ready = 1'b1;
   logic [3:0] repeat_n = 4'd1;

   logic [2:0] d0, d2;
   logic       v0, v2, b0, b2, dn0, dn2;
   logic [3:0] c0, c2;

   typedef struct packed {
      logic [2:0] data;
      logic       valid;
      logic       busy;
      logic       done;
      logic [3:0] cnt;
   } out_t;

   typedef struct {
      logic       start;
      logic       abort;
      logic       ready;
      logic [3:0] rn;
      out_t       exp;
   } vec_t;

   typedef struct {
      string name;
      out_t  e0;
      out_t  e2;
   } sb_t;

   sb_t        sbq[$];
   vec_t       vt[$];
   out_t       q0[$], q2[$];
   logic [2:0] pat [0:6];
   int         checks = 0;
   int         errors = 0;

   seq_pattern_generator #(.IDLE_SYMBOL(3'b111), .GAP_CYCLES(0), .CNT_W(4)) u0 (
      .clk(clk), .reset_n(reset_n), .start(start), .repeat_n(repeat_n), .abort(abort),
      .ready(ready), .data(d0), .data_valid(v0), .busy(b0), .done(dn0), .seq_count(c0));

   seq_pattern_generator #(.IDLE_SYMBOL(3'b111), .GAP_CYCLES(2), .CNT_W(4)) u2 (
      .clk(clk), .reset_n(reset_n), .start(start), .repeat_n(repeat_n), .abort(abort),
      .ready(ready), .data(d2), .data_valid(v2), .busy(b2), .done(dn2), .seq_count(c2));

   always #5 clk = ~clk;

   function automatic out_t o(input logic [2:0] d, input logic v, input logic b,
                              input logic dn, input logic [3:0] c);
      out_t r;
      r.data = d; r.valid = v; r.busy = b; r.done = dn; r.cnt = c;
      return r;
   endfunction

   function automatic out_t idle_o(input logic [3:0] c);
      return o(3'b111, 1'b0, 1'b0, 1'b0, c);
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got data=%b valid=%b busy=%b done=%b cnt=%0d, expected data=%b valid=%b busy=%b done=%b cnt=%0d",
                  name, act.data, act.valid, act.busy, act.done, act.cnt,
                  exp.data, exp.valid, exp.busy, exp.done, exp.cnt);
      end
   endtask

   task automatic check_both(input string name, input out_t e0, input out_t e2);
      check({name, "/u0"}, o(d0, v0, b0, dn0, c0), e0);
      check({name, "/u2"}, o(d2, v2, b2, dn2, c2), e2);
   endtask

   // Drive one cycle of inputs, queue the outputs required after the next edge, then compare.
   task automatic step(input string name, input logic st, input logic ab, input logic rd,
                       input logic [3:0] rn, input out_t e0, input out_t e2);
      sb_t item;
      @(negedge clk);
      start = st; abort = ab; ready = rd; repeat_n = rn;
      item.name = name; item.e0 = e0; item.e2 = e2;
      sbq.push_back(item);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty, required one pending entry", name);
      end else begin
         item = sbq.pop_front();
         check_both(item.name, item.e0, item.e2);
      end
   endtask

   task automatic addv(input logic st, input logic ab, input logic rd, input logic [3:0] rn,
                       input out_t e);
      vec_t v;
      v.start = st; v.abort = ab; v.ready = rd; v.rn = rn; v.exp = e;
      vt.push_back(v);
   endtask

   task automatic single_run(input string name);
      step({name, "_s0"}, 1'b1, 1'b0, 1'b1, 4'd1, o(pat[0], 1, 1, 0, 0), o(pat[0], 1, 1, 0, 0));
      for (int i = 1; i < 7; i++)
         step($sformatf("%s_s%0d", name, i), 1'b0, 1'b0, 1'b1, 4'd1,
              o(pat[i], 1, 1, 0, 0), o(pat[i], 1, 1, 0, 0));
      step({name, "_done"}, 1'b0, 1'b0, 1'b1, 4'd1, o(3'b111, 0, 0, 1, 1), o(3'b111, 0, 0, 1, 1));
      step({name, "_idle"}, 1'b0, 1'b0, 1'b1, 4'd1, idle_o(1), idle_o(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1);
   end

   initial begin
      pat[0] = 3'b001; pat[1] = 3'b101; pat[2] = 3'b110; pat[3] = 3'b000;
      pat[4] = 3'b110; pat[5] = 3'b110; pat[6] = 3'b011;

      // Single run, repeat_n=1
      addv(1, 0, 1, 1, o(pat[0], 1, 1, 0, 0));
      for (int i = 1; i < 7; i++) addv(0, 0, 1, 1, o(pat[i], 1, 1, 0, 0));
      addv(0, 0, 1, 1, o(3'b111, 0, 0, 1, 1));
      addv(0, 0, 1, 1, idle_o(1));
      // Back-pressure: three ready=0 cycles while idx=2 is shown
      addv(1, 0, 1, 1, o(pat[0], 1, 1, 0, 0));
      addv(0, 0, 1, 1, o(pat[1], 1, 1, 0, 0));
      addv(0, 0, 1, 1, o(pat[2], 1, 1, 0, 0));
      for (int i = 0; i < 3; i++) addv(0, 0, 0, 1, o(pat[2], 1, 1, 0, 0));
      for (int i = 3; i < 7; i++) addv(0, 0, 1, 1, o(pat[i], 1, 1, 0, 0));
      addv(0, 0, 1, 1, o(3'b111, 0, 0, 1, 1));
      // repeat_n=0 acts as 1; a start mid-run is ignored
      addv(1, 0, 1, 0, o(pat[0], 1, 1, 0, 0));
      addv(0, 0, 1, 0, o(pat[1], 1, 1, 0, 0));
      addv(1, 0, 1, 5, o(pat[2], 1, 1, 0, 0));
      for (int i = 3; i < 7; i++) addv(0, 0, 1, 0, o(pat[i], 1, 1, 0, 0));
      addv(0, 0, 1, 0, o(3'b111, 0, 0, 1, 1));
      addv(0, 0, 1, 0, idle_o(1));
      // start together with abort in IDLE stays idle
      addv(1, 1, 1, 3, idle_o(1));
      addv(0, 0, 1, 3, idle_o(1));

      // Expected waveforms for a repeat_n=3 run on each instance
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 7; i++) begin
            q0.push_back(o(pat[i], 1, 1, 0, 4'(s)));
            q2.push_back(o(pat[i], 1, 1, 0, 4'(s)));
         end
         if (s < 2) begin
            q2.push_back(o(3'b111, 0, 1, 0, 4'(s + 1)));
            q2.push_back(o(3'b111, 0, 1, 0, 4'(s + 1)));
         end
      end
      q0.push_back(o(3'b111, 0, 0, 1, 3));
      q2.push_back(o(3'b111, 0, 0, 1, 3));

      // Reset state, asserted asynchronously before any clock edge
      #1 reset_n = 1'b0;
      #1 check_both("reset", idle_o(0), idle_o(0));
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      for (int i = 0; i < vt.size(); i++)
         step($sformatf("tbl%0d", i), vt[i].start, vt[i].abort, vt[i].ready, vt[i].rn,
              vt[i].exp, vt[i].exp);

      // Repeat run: back-to-back on u0, two-cycle gaps on u2
      for (int k = 0; k <= q2.size(); k++)
         step($sformatf("rep%0d", k), k == 0, 1'b0, 1'b1, 4'd3,
              (k < q0.size()) ? q0[k] : idle_o(3),
              (k < q2.size()) ? q2[k] : idle_o(3));

      // Abort while u2 shows idx 4 of its second sequence
      for (int k = 0; k < 14; k++)
         step($sformatf("abt%0d", k), k == 0, 1'b0, 1'b1, 4'd3, q0[k], q2[k]);
      step("abt_abort", 1'b0, 1'b1, 1'b1, 4'd3, idle_o(1), idle_o(1));
      step("abt_after", 1'b0, 1'b0, 1'b1, 4'd3, idle_o(1), idle_o(1));
      single_run("restart");

      // Reset asserted while u2 is in its gap
      for (int k = 0; k < 8; k++)
         step($sformatf("rst%0d", k), k == 0, 1'b0, 1'b1, 4'd3, q0[k], q2[k]);
      #2 reset_n = 1'b0;
      #1 check_both("rst_async", idle_o(0), idle_o(0));
      step("rst_hold0", 1'b0, 1'b0, 1'b1, 4'd3, idle_o(0), idle_o(0));
      step("rst_hold1", 1'b1, 1'b0, 1'b1, 4'd3, idle_o(0), idle_o(0));
      @(negedge clk) reset_n = 1'b1;
      start = 1'b0;
      single_run("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_pattern_generator.md
# seq_pattern_generator

Transmit-side counterpart of the 3-bit sequence detector. On a start request, the block emits the fixed 7-symbol pattern 3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011 on a 3-bit symbol bus, one symbol per accepted cycle. It supports back-pressure, a programmable repeat count with inter-sequence gaps, and abort. It serves as the stimulus/transmit source feeding detector instances and as a link-test pattern source.

## Interface
- IDLE_SYMBOL, 3'b111: value driven on data whenever no symbol is valid; must not equal 3'b001.
- GAP_CYCLES, 0: idle cycles inserted between repeated sequences (0..255).
- CNT_W, 4: width of repeat_n and seq_count.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a run; sampled only in IDLE.
- repeat_n  in  CNT_W  sequences per run; latched at start; 0 treated as 1.
- abort  in  1  terminate the current run immediately.
- ready  in  1  downstream accepts data this cycle when data_valid=1.
- data  out  3  current symbol (registered).
- data_valid  out  1  data holds a pattern symbol.
- busy  out  1  run in progress (SEND or GAP).
- done  out  1  one-cycle pulse on normal completion of a run.
- seq_count  out  CNT_W  sequences completed in the current or last run.

## Operation
- States:
  - IDLE: data=IDLE_SYMBOL, data_valid=0, busy=0.
  - SEND: data=pattern[idx], data_valid=1, busy=1.
  - GAP: data=IDLE_SYMBOL, data_valid=0, busy=1.
- idx is 0..6. A symbol is accepted on any cycle in SEND with ready=1. idx advances only on acceptance; data is held while ready=0.
- IDLE -> SEND on start=1 and abort=0: latch repeat_n (0 -> 1), set idx=0, clear seq_count.
- Acceptance with idx=6: seq_count increments (no wrap past the latched target). Next state:
  - seq_count(new) < target and GAP_CYCLES=0: SEND with idx=0, back-to-back.
  - seq_count(new) < target and GAP_CYCLES>0: GAP for exactly GAP_CYCLES cycles, then SEND with idx=0.
  - seq_count(new) = target: IDLE, with done=1 for that one cycle.
- abort=1 in SEND or GAP: next cycle IDLE. No done pulse. seq_count holds its value. A partial sequence is discarded.
- abort has priority over start and ready in all states. start with abort in IDLE is ignored.
- start while busy=1 is ignored; the run is not restarted.
- seq_count holds after a run until the next accepted start.
- Downstream detectors sample every cycle with no valid qualifier. When driving such a detector, tie ready=1 and keep GAP_CYCLES at 0 or any value; gaps show IDLE_SYMBOL.

## Timing
- Reset (asynchronous, any state): state=IDLE, data=IDLE_SYMBOL, data_valid=0, busy=0, done=0, seq_count=0, idx=0. A mid-run reset yields no done pulse.
- Start latency: start sampled at edge N; data=3'b001, data_valid=1, busy=1 from edge N until the next edge.
- With ready=1 constantly, symbols occupy cycles N..N+6, one per cycle.
- done is asserted in cycle N+7 and busy=0 in the same cycle (single run, no stall).
- Each ready=0 cycle in SEND extends the run by one cycle.
- In GAP, ready is ignored.
- Repeat run: sequence k+1 symbol 0 appears GAP_CYCLES cycles after the cycle following sequence k's final acceptance. With GAP_CYCLES=0 it appears in the immediately following cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single run: repeat_n=1, ready=1, GAP_CYCLES=0, start at cycle 0.
  - Expect data 1,5,6,0,6,6,3 with data_valid=1 on cycles 1..7.
  - Expect done=1 and busy=0 on cycle 8, seq_count=1.
  - A detector on the bus flags found on cycle 7.
- Repeat with gap: repeat_n=3, GAP_CYCLES=2, ready=1.
  - Expect 3 patterns each separated by 2 cycles of data=3'b111 with data_valid=0.
  - Expect done once, after the third pattern; seq_count=3.
- Back-pressure: ready=0 for 3 cycles while idx=2.
  - Expect data held at 3'b110 for 4 cycles, then the sequence continues.
  - Expect total run length 10 cycles, no symbol skipped or duplicated on acceptance.
- Abort: abort=1 on symbol idx=4 of sequence 2 of a repeat_n=3 run.
  - Next cycle: IDLE, data=3'b111, busy=0, no done, seq_count=1.
  - A new start is accepted afterwards.
- Corner inputs:
  - repeat_n=0: exactly one pattern, seq_count=1.
  - start pulsed mid-run: ignored.
  - start and abort together in IDLE: remains IDLE.
- Reset mid-run: reset_n low during GAP.
  - All outputs take reset values asynchronously; no done pulse.
  - After release, start behaves as in the single-run case.
